pdm_mic_array_frontend: RTL and testbench

Multi-channel PDM microphone front end for the audio path. It generates the shared PDM mic clock from clk_in (98.3 MHz) and samples NUM_CH mic data lines. Each channel's 1-bit stream is decimated by tally-and-dump into signed PCM samples. One sample frame per decimation period goes out over a valid/ready handshake, with overrun detection, to downstream filtering/DSP.

---
 rtl/pdm_mic_array_frontend.sv | 150 +++++++++++++++
 tb/tb_pdm_mic_array_frontend.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_array_frontend.sv
// pdm_mic_array_frontend
//   Multi-channel PDM microphone front end. Divides clk_in down to the shared
//   PDM mic clock and samples NUM_CH mic data lines through 2-flop
//   synchronisers. Each channel counts its ones over DECIM PDM bits and turns
//   the count into a signed W-bit PCM sample. One frame per decimation period
//   is offered on a valid/ready handshake. A sticky flag records frames that
//   were overwritten before they were accepted.
//
//   Ports:
//     clk_in            system clock
//     rst_in            asynchronous, active-high reset
//     enable_in         run enable; low stops the mic clock and drops the partial frame
//     mic_data_in       raw PDM bits, one per mic, asynchronous to clk_in
//     mic_clk_out       PDM clock to all mics (50% duty, starts low)
//     samples_out       signed samples, channel k at [k*W +: W]
//     sample_valid_out  frame available
//     sample_ready_in   consumer accepts the frame when valid && ready
//     overrun_out       sticky overrun flag
//     clr_overrun_in    clears overrun_out (a simultaneous set wins)

// Per-channel synchroniser, ones counter and PCM conversion.
module pdm_mic_lane #(
   parameter int DECIM = 256,
   parameter int W     = $clog2(DECIM) + 1
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         enable_in,
   input  logic         mic_data_in,
   input  logic         pdm_step,
   input  logic         frame_end,
   output logic [W-1:0] sample
);
   logic [1:0]   sync;
   logic [W-1:0] tally;
   logic [W-1:0] tally_fin;
   logic [W:0]   diff;
   logic [W-1:0] conv;

   // The final count of a frame includes the bit sampled on the frame-end step.
   assign tally_fin = tally + {{(W-1){1'b0}}, sync[1]};
   // 2*tally - DECIM, one bit wider so that tally == DECIM is still representable.
   assign diff      = {tally_fin, 1'b0} - (W+1)'(DECIM);
   // Only an all-ones frame exceeds the positive range; clamp it to DECIM-1.
   assign conv      = ($signed(diff) > $signed((W+1)'(DECIM-1))) ? W'(DECIM-1) : diff[W-1:0];

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync   <= '0;
         tally  <= '0;
         sample <= '0;
      end else begin
         sync <= {sync[0], mic_data_in};
         if (!enable_in || frame_end)
            tally <= '0;
         else if (pdm_step)
            tally <= tally_fin;
         if (frame_end)
            sample <= conv;
      end
   end
endmodule

module pdm_mic_array_frontend #(
   parameter int NUM_CH  = 3,
   parameter int CLK_DIV = 32,
   parameter int DECIM   = 256,
   localparam int W      = $clog2(DECIM) + 1
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                enable_in,
   input  logic [NUM_CH-1:0]   mic_data_in,
   output logic                mic_clk_out,
   output logic [NUM_CH*W-1:0] samples_out,
   output logic                sample_valid_out,
   input  logic                sample_ready_in,
   output logic                overrun_out,
   input  logic                clr_overrun_in
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DECIM);

   logic [CW-1:0]             cnt;
   logic [CW-1:0]             cnt_nxt;
   logic [BW-1:0]             bitcnt;
   logic                      pdm_step;
   logic                      frame_end;
   logic [NUM_CH-1:0][W-1:0]  samples;

   always_comb begin
      cnt_nxt = '0;
      if (enable_in && (cnt != CW'(CLK_DIV-1)))
         cnt_nxt = cnt + 1'b1;
   end

   // Sample on the last high cycle of the mic clock, just before it falls.
   assign pdm_step  = enable_in && (cnt == CW'(CLK_DIV-1));
   assign frame_end = pdm_step && (bitcnt == BW'(DECIM-1));

   // mic_clk_out is registered from the next count so it lines up with cnt:
   // high exactly while cnt is in the upper half of the period.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt         <= '0;
         bitcnt      <= '0;
         mic_clk_out <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         mic_clk_out <= enable_in && (cnt_nxt >= CW'(CLK_DIV/2));
         if (!enable_in)
            bitcnt <= '0;
         else if (pdm_step)
            bitcnt <= bitcnt + 1'b1;   // DECIM is a power of two, so this wraps
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      pdm_mic_lane #(.DECIM(DECIM), .W(W)) u_lane (
         .clk_in      (clk_in),
         .rst_in      (rst_in),
         .enable_in   (enable_in),
         .mic_data_in (mic_data_in[g]),
         .pdm_step    (pdm_step),
         .frame_end   (frame_end),
         .sample      (samples[g])
      );
   end

   assign samples_out = samples;

   // A new frame always wins over acceptance of the old one; it is an overrun
   // only if the pending frame was never taken.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sample_valid_out <= 1'b0;
         overrun_out      <= 1'b0;
      end else begin
         if (frame_end)
            sample_valid_out <= 1'b1;
         else if (sample_valid_out && sample_ready_in)
            sample_valid_out <= 1'b0;

         if (frame_end && sample_valid_out && !sample_ready_in)
            overrun_out <= 1'b1;
         else if (clr_overrun_in)
            overrun_out <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pdm_mic_array_frontend.sv
module tb_pdm_mic_array_frontend;
   localparam logic [8:0] P = 9'h0FF;   // +255 (saturated all-ones)
   localparam logic [8:0] N = 9'h100;   // -256 (all-zeros)
   localparam logic [8:0] Z = 9'h000;   //    0 (half ones)
   localparam logic [8:0] H = 9'h080;   // +128 (192 ones)

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default-parameter instance
   logic        rst, enable, ready, clr;
   logic [2:0]  mic_data = 3'b000;
   logic        mic_clk, valid, overrun;
   logic [26:0] samples;

   // small instance: DECIM=4, CLK_DIV=4, W=3
   logic        rst_s, en_s, ready_s, clr_s;
   logic [1:0]  data_s;
   logic        mclk_s, valid_s, ovr_s;
   logic [5:0]  samp_s;

   int checks = 0;
   int errors = 0;
   int pat    = 0;
   int k      = 0;

   pdm_mic_array_frontend dut (
      .clk_in(clk), .rst_in(rst), .enable_in(enable), .mic_data_in(mic_data),
      .mic_clk_out(mic_clk), .samples_out(samples), .sample_valid_out(valid),
      .sample_ready_in(ready), .overrun_out(overrun), .clr_overrun_in(clr)
   );

   pdm_mic_array_frontend #(.NUM_CH(2), .CLK_DIV(4), .DECIM(4)) dut_s (
      .clk_in(clk), .rst_in(rst_s), .enable_in(en_s), .mic_data_in(data_s),
      .mic_clk_out(mclk_s), .samples_out(samp_s), .sample_valid_out(valid_s),
      .sample_ready_in(ready_s), .overrun_out(ovr_s), .clr_overrun_in(clr_s)
   );

   // PDM data source: new bit on each mic clock rise, k = bit index since enable.
   always @(posedge mic_clk or negedge enable) begin
      if (!enable) k = 0;
      else begin
         case (pat)
            0:       mic_data = 3'b111;
            1:       mic_data = 3'b000;
            2:       mic_data = {2'b01, k[0]};
            default: mic_data = {2'b01, ((k % 4) != 3)};
         endcase
         k++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; ready = 1'b1; clr = 1'b0;
      rst_s = 1'b1; en_s = 1'b1; ready_s = 1'b0; clr_s = 1'b0; data_s = 2'b11;
      #21;
      check("rst_mic_clk", mic_clk, 0);
      check("rst_valid",   valid,   0);
      check("rst_samples", samples, 0);
      check("rst_overrun", overrun, 0);
      #1 rst = 1'b0;                       // released between edges; cycle 0 starts

      // mic clock: low for 16 cycles, high for 16
      step(15); check("mclk_lo0", mic_clk, 0);
      step(1);  check("mclk_hi0", mic_clk, 1);
      step(15); check("mclk_hi1", mic_clk, 1);
      step(1);  check("mclk_lo1", mic_clk, 0);

      // frame 1: all ones
      step(8159); check("f1_valid_early", valid, 0);
      step(1);    check("f1_valid", valid, 1);
      check("f1_samples", samples, {P, P, P});
      check("f1_overrun", overrun, 0);
      pat = 1;
      step(1);    check("f1_accept_drop", valid, 0);
      check("f1_hold", samples, {P, P, P});

      // frame 2: all zeros
      step(8191); check("f2_valid", valid, 1);
      check("f2_samples", samples, {N, N, N});
      pat = 2;

      // frame 3: ch0 toggling, ch1 ones, ch2 zeros
      step(8192); check("f3_samples", samples, {N, P, Z});
      pat = 3;

      // frame 4: ch0 has 192 ones
      step(8192); check("f4_samples", samples, {N, P, H});
      ready = 1'b0; pat = 0;

      // frame 5 overwrites the unaccepted frame 4
      step(8191); check("f5_pre_valid", valid, 1);
      check("f5_pre_overrun", overrun, 0);
      check("f5_pre_hold", samples, {N, P, H});
      step(1);    check("f5_samples", samples, {P, P, P});
      check("f5_overrun", overrun, 1);
      check("f5_valid", valid, 1);
      pat = 1;
      clr = 1'b1; step(1); clr = 1'b0;
      check("clr_overrun", overrun, 0);

      // frame 6: overrun set and clear in the same cycle, set wins
      step(8190); clr = 1'b1;
      step(1);    clr = 1'b0;
      check("f6_set_wins", overrun, 1);
      check("f6_samples", samples, {N, N, N});
      pat = 2;
      clr = 1'b1; step(1); clr = 1'b0;
      check("clr_overrun2", overrun, 0);

      // frame 7: ready rises exactly on the frame-end cycle
      step(8190); ready = 1'b1;
      step(1);    ready = 1'b0;
      check("f7_valid", valid, 1);
      check("f7_overrun", overrun, 0);
      check("f7_samples", samples, {N, P, Z});
      pat = 0;

      // frame 8: disable mid bit 100 while the mic clock is high
      step(3216); check("dis_mclk_before", mic_clk, 1);
      enable = 1'b0;
      step(1);    check("dis_mclk", mic_clk, 0);
      check("dis_valid_kept", valid, 1);
      check("dis_samples_kept", samples, {N, P, Z});
      step(48);   check("dis_mclk_still", mic_clk, 0);
      ready = 1'b1;
      step(1);    ready = 1'b0;
      check("dis_handshake", valid, 0);
      check("dis_samples_hold", samples, {N, P, Z});
      enable = 1'b1; pat = 3;

      // fresh frame after re-enable, only post-enable data
      step(8191); check("reen_valid_early", valid, 0);
      step(1);    check("reen_valid", valid, 1);
      check("reen_samples", samples, {N, P, H});

      // asynchronous reset mid-frame
      step(20);   check("pre_rst_mclk", mic_clk, 1);
      #3 rst = 1'b1;
      #1;
      check("arst_mclk", mic_clk, 0);
      check("arst_valid", valid, 0);
      check("arst_samples", samples, 0);
      check("arst_overrun", overrun, 0);

      // small instance
      @(negedge clk); rst_s = 1'b0;
      step(2);  check("s_mclk", mclk_s, 1);
      step(13); check("s_valid_early", valid_s, 0);
      step(1);  check("s_valid", valid_s, 1);
      check("s_ones", samp_s, {3'b011, 3'b011});
      data_s = 2'b00;
      step(16); check("s_zeros", samp_s, {3'b100, 3'b100});
      check("s_overrun", ovr_s, 1);
      step(3);  check("s_pre_rst_mclk", mclk_s, 1);
      #3 rst_s = 1'b1;
      #1;
      check("s_arst_samples", samp_s, 0);
      check("s_arst_valid", valid_s, 0);
      check("s_arst_overrun", ovr_s, 0);
      check("s_arst_mclk", mclk_s, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
